cp0_regfile_gen2: RTL and testbench
===================================

// Module: cp0_regfile_gen2
// PURPOSE
//  Second-generation coprocessor-0 register file for the MIPS core. Holds Count/Compare/Status/Cause/EPC/
//  BadVAddr/Config/PRId, takes committed exceptions and ERET from MEM/WB, and raises one masked interrupt
//  request to the exception controller. New versus gen1: parametrised interrupt count, timer prescaler,
//  BadVAddr, write masks, exception vector output and a fixed priority for same-cycle events.
// PARAMETERS
//  DATA_W      32            register width; only 32 is legal
//  NUM_HW_INT  6             hardware interrupt lines, 1..6, mapped to Cause.IP[2+k]
//  TIMER_DIV   1             Count increments once every TIMER_DIV cycles, 1..256
//  EXC_BASE    32'h0000_0000 exception vector base address
//  PRID_VAL    32'h0001_8000 read-only PRId value
// PORTS
//  clk              in   1           core clock
//  rst_n            in   1           asynchronous active-low reset
//  we_i             in   1           mtc0 write enable
//  waddr_i          in   5           mtc0 register address
//  raddr_i          in   5           mfc0 register address
//  data_i           in   DATA_W      mtc0 write data
//  int_i            in   NUM_HW_INT  hardware interrupt levels, asynchronous to the pipeline
//  exc_valid_i      in   1           exception commits this cycle
//  exc_code_i       in   5           ExcCode of the committing exception
//  exc_pc_i         in   DATA_W      PC of the faulting instruction
//  exc_bd_i         in   1           faulting instruction is in a delay slot
//  exc_badvaddr_i   in   DATA_W      faulting address; used for AdEL/AdES only
//  eret_i           in   1           ERET commits this cycle
//  data_o           out  DATA_W      mfc0 read data, combinational
//  status_o         out  DATA_W      current Status
//  cause_o          out  DATA_W      current Cause
//  epc_o            out  DATA_W      current EPC
//  exc_vector_o     out  DATA_W      redirect target for the exception or ERET this cycle
//  int_req_o        out  1           IE & ~EXL & |(IP & IM), from registered state
//  timer_int_o      out  1           sticky timer-interrupt pending flag
// BEHAVIOUR
//  Reset (async, rst_n=0): Count=0, Compare=0, Status=32'h1000_0000, Cause=0, EPC=0, BadVAddr=0,
//   Config=32'h0000_8000, prescaler=0, int sync flop=0, timer_int_o=0, int_req_o=0.
//   Reset mid-operation drops any in-flight update; nothing is retained.
//  Priority per cycle, highest first: exception commit > ERET > mtc0 write > autonomous updates.
//   A lower-priority event is overridden only on the fields a higher-priority event writes.
//  Timer:
//   - Prescaler counts 0..TIMER_DIV-1. Its wrap to 0 is a tick; each tick adds 1 to Count (32-bit wrap).
//   - Match = tick & (Count+1==Compare) & Compare!=0. Match sets timer_int_o the same edge Count lands on Compare.
//   - mtc0 Compare writes Compare and clears timer_int_o; a same-cycle match is lost.
//   - mtc0 Count writes Count and resets the prescaler to 0.
//  Interrupts:
//   - int_i is registered once, then drives Cause.IP[2+NUM_HW_INT-1:2]; unused IP bits read 0.
//   - Cause[15] = timer_int_o | (NUM_HW_INT==6 ? synced int_i[5] : 0).
//   - Latency: int_i rising before edge n gives IP set after edge n, and int_req_o high in cycle n+1 if unmasked.
//  Write masks (unlisted bits hold their value):
//   - Status: CU0[28], IM[15:8], EXL[1], IE[0].
//   - Cause: IV[23], WP[22], IP[9:8] (software interrupts).
//   - EPC: all bits. Count and Compare: all bits.
//   - BadVAddr, Config and PRId are read-only; writes to them or to unknown addresses are ignored.
//  Exception commit (exc_valid_i=1):
//   - If EXL=0: EPC = exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD = exc_bd_i.
//   - If EXL=1 (nested): EPC and BD are unchanged.
//   - Always: EXL=1 and ExcCode = exc_code_i.
//   - BadVAddr = exc_badvaddr_i when exc_code_i is 4 or 5.
//  ERET without an exception in the same cycle: EXL=0.
//  exc_vector_o:
//   - ERET: current EPC, or data_i when mtc0 writes EPC in the same cycle (forwarded).
//   - Exception: EXC_BASE + (exc_code_i==0 && IV ? 32'h200 : 32'h180).
//   - Otherwise: 0.
//  Read data_o: selected register; Cause and Status reflect pre-edge state. Unknown address returns 0.
// STRUCTURE
//  Package cp0_pkg holds the CP0_REG_* addresses (9,11,12,13,14,8,16,15), the EXC_* codes
//   (INT=0, ADEL=4, ADES=5, SYS=8, RI=10, OV=12, TR=13) and the Status/Cause bit-index localparams.
//  One sub-module, cp0_timer: prescaler plus Count/Compare plus the sticky match flag, with write ports
//   for Count and Compare.
// TESTING
//  1 TIMER_DIV=4, write Compare=3 -> Count reaches 3 on the 12th cycle after reset, timer_int_o rises
//    that edge, Cause[15]=1; write Compare=0 -> timer_int_o=0 the next cycle.
//  2 Status=32'h0000_0401, int_i[0] pulsed high -> Cause[10]=1 after one edge, int_req_o=1 the cycle after;
//    set EXL -> int_req_o=0.
//  3 exc_valid_i with code 10, pc=32'h0000_0100, bd=1 -> EPC=32'h0000_00FC, Cause[31]=1, ExcCode=10,
//    EXL=1, exc_vector_o=32'h180.
//  4 Nested exception with code 12 while EXL=1 -> EPC unchanged, ExcCode=12; then eret_i -> EXL=0,
//    exc_vector_o=EPC.
//  5 Same cycle: mtc0 EPC=32'h400 with eret_i -> exc_vector_o=32'h400; mtc0 Status with exc_valid_i
//    -> EXL=1 regardless of data_i[1].
//  6 Assert rst_n=0 asynchronously mid-count with timer_int_o=1 -> all registers and outputs at reset
//    values before the next clk edge.

Source files
------------

// File: rtl/cp0_regfile_gen2_pkg.sv
// CP0 register addresses, exception codes and Status/Cause field positions
// shared by the gen2 coprocessor-0 register file.
package cp0_pkg;

    typedef enum logic [4:0] {
        CP0_REG_BADVADDR = 5'd8,
        CP0_REG_COUNT    = 5'd9,
        CP0_REG_COMPARE  = 5'd11,
        CP0_REG_STATUS   = 5'd12,
        CP0_REG_CAUSE    = 5'd13,
        CP0_REG_EPC      = 5'd14,
        CP0_REG_PRID     = 5'd15,
        CP0_REG_CONFIG   = 5'd16
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned STATUS_IM_LSB = 8;
    localparam int unsigned STATUS_CU0    = 28;
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 8;
    localparam int unsigned CAUSE_HW_LSB  = 10;
    localparam int unsigned CAUSE_WP      = 22;
    localparam int unsigned CAUSE_IV      = 23;
    localparam int unsigned CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;
    localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;
    localparam logic [31:0] VEC_GENERAL  = 32'h0000_0180;
    localparam logic [31:0] VEC_INTR     = 32'h0000_0200;

    function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_regfile_gen2_if.sv
// Pipeline-side bus of the CP0 register file: mtc0/mfc0 access plus
// exception/ERET commit from MEM/WB and the redirect vector back.
interface cp0_regfile_gen2_if #(
    parameter int unsigned DATA_W = 32
);
    logic              we_i;
    logic [4:0]        waddr_i;
    logic [4:0]        raddr_i;
    logic [DATA_W-1:0] data_i;
    logic              exc_valid_i;
    logic [4:0]        exc_code_i;
    logic [DATA_W-1:0] exc_pc_i;
    logic              exc_bd_i;
    logic [DATA_W-1:0] exc_badvaddr_i;
    logic              eret_i;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] exc_vector_o;

    modport master (
        output we_i, waddr_i, raddr_i, data_i, exc_valid_i, exc_code_i,
               exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        input  data_o, exc_vector_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, exc_valid_i, exc_code_i,
               exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        output data_o, exc_vector_o
    );
endinterface

// File: rtl/cp0_regfile_gen2_timer.sv
// CP0 timer: prescaled Count, Compare and the sticky match flag.
// A Count write restarts the prescaler and suppresses that cycle's tick.
module cp0_timer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              count_we_i,
    input  logic              compare_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] count_o,
    output logic [DATA_W-1:0] compare_o,
    output logic              timer_int_o
);
    localparam int unsigned   PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              tint_q, tint_d;
    logic              tick, match;

    always_comb begin
        tick      = (presc_q == PRESC_MAX) && !count_we_i;
        match     = tick && (count_q + DATA_W'(1) == compare_q) && (compare_q != '0);
        presc_d   = (count_we_i || tick) ? '0 : presc_q + PW'(1);
        count_d   = count_we_i ? wdata_i : (tick ? count_q + DATA_W'(1) : count_q);
        compare_d = compare_we_i ? wdata_i : compare_q;
        tint_d    = compare_we_i ? 1'b0 : (tint_q | match);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            tint_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            tint_q    <= tint_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = tint_q;
endmodule

// File: rtl/cp0_regfile_gen2.sv
// Gen2 CP0 register file: Status/Cause/EPC/BadVAddr state, exception and
// ERET commit with fixed priority, masked interrupt request and vector output.
module cp0_regfile_gen2
    import cp0_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_HW_INT = 6,
    parameter int unsigned TIMER_DIV  = 1,
    parameter logic [31:0] EXC_BASE   = 32'h0000_0000,
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cp0_regfile_gen2_if.slave     bus,
    input  logic [NUM_HW_INT-1:0] int_i,
    output logic [DATA_W-1:0]     status_o,
    output logic [DATA_W-1:0]     cause_o,
    output logic [DATA_W-1:0]     epc_o,
    output logic                  int_req_o,
    output logic                  timer_int_o
);
    logic [DATA_W-1:0]     status_q, status_d;
    logic [DATA_W-1:0]     cause_q, cause_d;
    logic [DATA_W-1:0]     epc_q, epc_d;
    logic [DATA_W-1:0]     badvaddr_q, badvaddr_d;
    logic [NUM_HW_INT-1:0] int_sync_q;
    logic [DATA_W-1:0]     count, compare;
    logic                  timer_int;
    logic                  wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [5:0]            hw_ip;

    assign wr_count   = bus.we_i && (bus.waddr_i == CP0_REG_COUNT);
    assign wr_compare = bus.we_i && (bus.waddr_i == CP0_REG_COMPARE);
    assign wr_status  = bus.we_i && (bus.waddr_i == CP0_REG_STATUS);
    assign wr_cause   = bus.we_i && (bus.waddr_i == CP0_REG_CAUSE);
    assign wr_epc     = bus.we_i && (bus.waddr_i == CP0_REG_EPC);

    cp0_timer #(
        .DATA_W    (DATA_W),
        .TIMER_DIV (TIMER_DIV)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_we_i   (wr_count),
        .compare_we_i (wr_compare),
        .wdata_i      (bus.data_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int)
    );

    // IP7 is shared between the timer and hardware line 5
    always_comb begin
        hw_ip    = 6'(int_sync_q);
        hw_ip[5] = hw_ip[5] | timer_int;
    end

    // mtc0 applied first; exception, then ERET, overwrite only their own fields
    always_comb begin
        status_d   = wr_status ? masked_write(status_q, bus.data_i, STATUS_WMASK) : status_q;
        cause_d    = wr_cause ? masked_write(cause_q, bus.data_i, CAUSE_WMASK) : cause_q;
        epc_d      = wr_epc ? bus.data_i : epc_q;
        badvaddr_d = badvaddr_q;
        if (bus.exc_valid_i) begin
            if (!status_q[STATUS_EXL]) begin
                epc_d             = bus.exc_bd_i ? bus.exc_pc_i - DATA_W'(4) : bus.exc_pc_i;
                cause_d[CAUSE_BD] = bus.exc_bd_i;
            end
            status_d[STATUS_EXL]          = 1'b1;
            cause_d[CAUSE_EXC_LSB +: 5]   = bus.exc_code_i;
            if (bus.exc_code_i == EXC_ADEL || bus.exc_code_i == EXC_ADES)
                badvaddr_d = bus.exc_badvaddr_i;
        end else if (bus.eret_i) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            int_sync_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            int_sync_q <= int_i;
        end
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q | (DATA_W'(hw_ip) << CAUSE_HW_LSB);
    assign epc_o       = epc_q;
    assign timer_int_o = timer_int;
    assign int_req_o   = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                         (|(cause_o[CAUSE_IP_LSB +: 8] & status_q[STATUS_IM_LSB +: 8]));

    always_comb begin
        if (bus.exc_valid_i)
            bus.exc_vector_o = EXC_BASE + ((bus.exc_code_i == EXC_INT && cause_q[CAUSE_IV])
                                           ? VEC_INTR : VEC_GENERAL);
        else if (bus.eret_i)
            bus.exc_vector_o = wr_epc ? bus.data_i : epc_q;
        else
            bus.exc_vector_o = '0;
    end

    always_comb begin
        case (bus.raddr_i)
            CP0_REG_BADVADDR: bus.data_o = badvaddr_q;
            CP0_REG_COUNT:    bus.data_o = count;
            CP0_REG_COMPARE:  bus.data_o = compare;
            CP0_REG_STATUS:   bus.data_o = status_o;
            CP0_REG_CAUSE:    bus.data_o = cause_o;
            CP0_REG_EPC:      bus.data_o = epc_q;
            CP0_REG_PRID:     bus.data_o = PRID_VAL;
            CP0_REG_CONFIG:   bus.data_o = CONFIG_VAL;
            default:          bus.data_o = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_regfile_gen2.sv
// Scoreboard bench for cp0_regfile_gen2: a driver updates a behavioural CP0
// model and queues expected outputs; a negedge monitor compares them.
module tb_cp0_regfile_gen2;
    localparam int unsigned TDIV = 4;
    localparam logic [31:0] PRID = 32'h0001_8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  int_i;
    logic [31:0] status_o, cause_o, epc_o;
    logic        int_req_o, timer_int_o;

    cp0_regfile_gen2_if #(.DATA_W(32)) bus ();

    cp0_regfile_gen2 #(
        .DATA_W     (32),
        .NUM_HW_INT (6),
        .TIMER_DIV  (TDIV),
        .EXC_BASE   (32'h0000_0000),
        .PRID_VAL   (PRID)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .int_i       (int_i),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .int_req_o   (int_req_o),
        .timer_int_o (timer_int_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [4:0]  raddr;
        logic [31:0] wdata;
        logic [5:0]  intr;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] bva;
        logic        eret;
    } stim_t;

    typedef struct {
        logic [31:0] data, vec, status, cause, epc;
        logic        int_req, timer;
    } resp_t;

    resp_t exp_q[$];
    int    passed = 0;
    int    total = 0;
    stim_t cur;

    // reference model state
    int unsigned m_cyc;
    logic [31:0] m_count, m_compare, m_status, m_epc, m_badv;
    logic        m_bd, m_iv, m_wp, m_timer;
    logic [1:0]  m_sw;
    logic [4:0]  m_exc;
    logic [5:0]  m_sync;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.we = 1'b0; s.waddr = '0; s.raddr = '0; s.wdata = '0; s.intr = '0;
        s.exc = 1'b0; s.code = '0; s.pc = '0; s.bd = 1'b0; s.bva = '0; s.eret = 1'b0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.we_i = s.we; bus.waddr_i = s.waddr; bus.raddr_i = s.raddr; bus.data_i = s.wdata;
        bus.exc_valid_i = s.exc; bus.exc_code_i = s.code; bus.exc_pc_i = s.pc;
        bus.exc_bd_i = s.bd; bus.exc_badvaddr_i = s.bva; bus.eret_i = s.eret;
        int_i = s.intr;
    endtask

    task automatic model_reset();
        m_cyc = 0; m_count = '0; m_compare = '0; m_status = 32'h1000_0000; m_epc = '0;
        m_badv = '0; m_bd = 0; m_iv = 0; m_wp = 0; m_timer = 0; m_sw = '0; m_exc = '0; m_sync = '0;
    endtask

    function automatic logic [31:0] m_cause();
        logic [31:0] c = '0;
        logic [5:0]  hw = m_sync;
        hw[5] = hw[5] | m_timer;
        c[31] = m_bd; c[23] = m_iv; c[22] = m_wp;
        c[15:10] = hw; c[9:8] = m_sw; c[6:2] = m_exc;
        return c;
    endfunction

    function automatic resp_t expect_now();
        resp_t       r;
        logic [31:0] c = m_cause();
        case (cur.raddr)
            5'd8:    r.data = m_badv;
            5'd9:    r.data = m_count;
            5'd11:   r.data = m_compare;
            5'd12:   r.data = m_status;
            5'd13:   r.data = c;
            5'd14:   r.data = m_epc;
            5'd15:   r.data = PRID;
            5'd16:   r.data = 32'h0000_8000;
            default: r.data = '0;
        endcase
        if (cur.exc)       r.vec = (cur.code == 5'd0 && m_iv) ? 32'h200 : 32'h180;
        else if (cur.eret) r.vec = (cur.we && cur.waddr == 5'd14) ? cur.wdata : m_epc;
        else               r.vec = '0;
        r.status  = m_status;
        r.cause   = c;
        r.epc     = m_epc;
        r.int_req = m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'd0);
        r.timer   = m_timer;
        return r;
    endfunction

    // one clock edge of the architectural behaviour, using inputs held in cur
    task automatic model_edge();
        bit tick, old_exl;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_exl = m_status[1];
        tick = ((m_cyc + 1) % TDIV) == 0;
        if (cur.we && cur.waddr == 5'd9) begin
            m_count = cur.wdata;
            m_cyc = 0;
        end else begin
            if (tick && m_compare != 0 && m_count + 32'd1 == m_compare) m_timer = 1;
            m_cyc = (m_cyc + 1) % TDIV;
            if (tick) m_count = m_count + 32'd1;
        end
        if (cur.we && cur.waddr == 5'd11) begin
            m_compare = cur.wdata;
            m_timer = 0;
        end
        if (cur.we && cur.waddr == 5'd12) begin
            m_status[28] = cur.wdata[28];
            m_status[15:8] = cur.wdata[15:8];
            m_status[1:0] = cur.wdata[1:0];
        end
        if (cur.we && cur.waddr == 5'd13) begin
            m_iv = cur.wdata[23]; m_wp = cur.wdata[22]; m_sw = cur.wdata[9:8];
        end
        if (cur.we && cur.waddr == 5'd14) m_epc = cur.wdata;
        if (cur.exc) begin
            if (!old_exl) begin
                m_epc = cur.bd ? cur.pc - 32'd4 : cur.pc;
                m_bd = cur.bd;
            end
            m_status[1] = 1;
            m_exc = cur.code;
            if (cur.code == 5'd4 || cur.code == 5'd5) m_badv = cur.bva;
        end else if (cur.eret) begin
            m_status[1] = 0;
        end
        m_sync = cur.intr;
    endtask

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        model_edge();
        rst_n = 1'b1;
        cur = s;
        apply(s);
        exp_q.push_back(expect_now());
        #1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s = idle();
        s.we = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 8))
            0: s.waddr = 5'd8;   1: s.waddr = 5'd9;   2: s.waddr = 5'd11;
            3: s.waddr = 5'd12;  4: s.waddr = 5'd13;  5: s.waddr = 5'd14;
            6: s.waddr = 5'd15;  7: s.waddr = 5'd16;
            default: s.waddr = 5'($urandom_range(0, 31));
        endcase
        s.raddr = 5'($urandom_range(0, 17));
        s.wdata = $urandom;
        if (s.waddr == 5'd11) s.wdata = ($urandom_range(0, 7) == 0) ? 32'd0 : m_count + $urandom_range(0, 3);
        if (s.waddr == 5'd9)  s.wdata = m_compare - $urandom_range(1, 3);
        s.intr = cur.intr ^ (($urandom_range(0, 3) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0);
        s.exc = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 6))
            0: s.code = 5'd0;  1: s.code = 5'd4;  2: s.code = 5'd5;  3: s.code = 5'd8;
            4: s.code = 5'd10; 5: s.code = 5'd12; default: s.code = 5'd13;
        endcase
        s.pc = $urandom & ~32'h3;
        s.bd = 1'($urandom_range(0, 1));
        s.bva = $urandom;
        s.eret = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    task automatic async_reset();
        @(posedge clk);
        #1;
        model_edge();
        cur = idle();
        cur.raddr = 5'd9;
        apply(cur);
        #1;
        chk("t6_timer_before_reset", timer_int_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_timer", timer_int_o, 0);
        chk("t6_status", status_o, 32'h1000_0000);
        chk("t6_cause", cause_o, 0);
        chk("t6_epc", epc_o, 0);
        chk("t6_int_req", int_req_o, 0);
        chk("t6_count", bus.data_o, 0);
        exp_q.push_back(expect_now());
    endtask

    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data_o", bus.data_o, e.data);
                chk("exc_vector_o", bus.exc_vector_o, e.vec);
                chk("status_o", status_o, e.status);
                chk("cause_o", cause_o, e.cause);
                chk("epc_o", epc_o, e.epc);
                chk("int_req_o", int_req_o, e.int_req);
                chk("timer_int_o", timer_int_o, e.timer);
            end
        end
    end

    initial begin
        stim_t s;
        model_reset();
        cur = idle();
        apply(cur);

        // timer: Compare=3 with a divide-by-4 prescaler
        s = idle(); s.we = 1; s.waddr = 5'd11; s.wdata = 32'd3; drive(s);
        for (int k = 1; k <= 12; k++) begin
            s = idle(); s.raddr = 5'd9; drive(s);
            if (k == 11) begin
                chk("t1_timer_before", timer_int_o, 0);
                chk("t1_count_before", bus.data_o, 2);
            end
            if (k == 12) begin
                chk("t1_count", bus.data_o, 3);
                chk("t1_timer_rise", timer_int_o, 1);
                chk("t1_cause15", cause_o[15], 1);
            end
        end
        s = idle(); s.we = 1; s.waddr = 5'd11; s.wdata = 32'd0; drive(s);
        drive(idle());
        chk("t1_timer_clear", timer_int_o, 0);

        // interrupt latency and EXL masking
        s = idle(); s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0000_0401; drive(s);
        s = idle(); s.intr = 6'd1; drive(s);
        drive(s);
        chk("t2_cause10", cause_o[10], 1);
        chk("t2_int_req", int_req_o, 1);
        s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0000_0403; drive(s);
        s = idle(); s.intr = 6'd1; drive(s);
        chk("t2_exl_masks", int_req_o, 0);
        drive(idle());

        // exception in a delay slot
        s = idle(); s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0; drive(s);
        s = idle(); s.exc = 1; s.code = 5'd10; s.pc = 32'h100; s.bd = 1; drive(s);
        chk("t3_vector", bus.exc_vector_o, 32'h180);
        drive(idle());
        chk("t3_epc", epc_o, 32'h0000_00FC);
        chk("t3_bd", cause_o[31], 1);
        chk("t3_exccode", cause_o[6:2], 10);
        chk("t3_exl", status_o[1], 1);

        // nested exception, then ERET
        s = idle(); s.exc = 1; s.code = 5'd12; s.pc = 32'h200; drive(s);
        drive(idle());
        chk("t4_epc_kept", epc_o, 32'h0000_00FC);
        chk("t4_exccode", cause_o[6:2], 12);
        s = idle(); s.eret = 1; drive(s);
        chk("t4_eret_vector", bus.exc_vector_o, 32'h0000_00FC);
        drive(idle());
        chk("t4_exl_clear", status_o[1], 0);

        // same-cycle priority cases
        s = idle(); s.eret = 1; s.we = 1; s.waddr = 5'd14; s.wdata = 32'h400; drive(s);
        chk("t5_eret_fwd", bus.exc_vector_o, 32'h400);
        s = idle(); s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0; s.exc = 1; s.code = 5'd8; s.pc = 32'h300; drive(s);
        drive(idle());
        chk("t5_exl_forced", status_o[1], 1);
        chk("t5_epc", epc_o, 32'h300);
        s = idle(); s.we = 1; s.waddr = 5'd13; s.wdata = 32'h0080_0000; s.eret = 1; drive(s);
        s = idle(); s.exc = 1; s.code = 5'd0; drive(s);
        chk("t5_iv_vector", bus.exc_vector_o, 32'h200);
        s = idle(); s.exc = 1; s.code = 5'd4; s.bva = 32'hDEAD_BEE0; drive(s);
        s = idle(); s.raddr = 5'd8; drive(s);
        chk("t5_badvaddr", bus.data_o, 32'hDEAD_BEE0);

        for (int n = 0; n < 2000; n++) drive(rand_stim());

        // arm the timer, then reset asynchronously mid-count
        s = idle(); s.we = 1; s.waddr = 5'd9; s.wdata = 32'd10; drive(s);
        s = idle(); s.we = 1; s.waddr = 5'd11; s.wdata = 32'd12; drive(s);
        for (int k = 0; k < 10; k++) drive(idle());
        async_reset();
        s = idle(); s.raddr = 5'd12; drive(s);
        for (int k = 0; k < 4; k++) drive(rand_stim());
        drive(idle());

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
